hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It sits beside ID/EX and drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. Inputs are the operand addresses decoded in ID, the destination and control bits in EX, and the branch/jump/mul-div events. It detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and freezes the front end while a multi-cycle mul/div occupies EX.

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/muldiv_stall_fsm.sv | 97 +++++++++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and constants for the 5-stage pipeline control blocks.
//   - muldiv_state_e : state of the mul/div EX-occupancy tracker
//   - REG_ZERO       : architectural $zero register number (never a hazard)
//   - MULDIV_LAT_MAX : largest supported mul/div latency (cycles in EX)
//   - reg_hit()      : "instruction reads register a and a equals d" test
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BUSY = 2'd1,
        LAST = 2'd2
    } muldiv_state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MULDIV_LAT_MAX = 32;

    function automatic logic reg_hit(input logic       uses,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/muldiv_stall_fsm.sv
// -----------------------------------------------------------------------------
// muldiv_stall_fsm
//   Tracks how long a mul/div instruction has been sitting in EX and tells the
//   hazard controller when to freeze the front end and when the result is
//   ready. A mul/div of latency MULDIV_LAT produces MULDIV_LAT-1 stall cycles
//   followed by one muldiv_done cycle, after which it leaves EX.
//
//   Parameters
//     MULDIV_LAT      cycles a mul/div occupies EX (legal 1..MULDIV_LAT_MAX)
//   Ports
//     clk             clock
//     reset           synchronous, active-low reset
//     ex_muldiv_i     EX holds a mult/multu/div/divu (sampled in RUN only)
//     muldiv_stall_o  freeze request for the front end this cycle
//     muldiv_done_o   mul/div result valid this cycle
//     state_o         current FSM state (debug visibility)
//
//   There is no handshake: ex_muldiv_i is a level sampled every cycle and
//   must be stable before the rising edge.
// -----------------------------------------------------------------------------
module muldiv_stall_fsm
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_muldiv_i,
    output logic          muldiv_stall_o,
    output logic          muldiv_done_o,
    output muldiv_state_e state_o
);

    // BUSY counts down from here; RUN and LAST supply the other two cycles.
    localparam logic [4:0] CNT_INIT = (MULDIV_LAT >= 3) ? 5'(MULDIV_LAT - 3) : 5'd0;

    muldiv_state_e state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          stall_c, done_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_muldiv_i) begin
                    if (MULDIV_LAT == 1) begin
                        done_c = 1'b1;
                    end else if (MULDIV_LAT == 2) begin
                        stall_c = 1'b1;
                        state_d = LAST;
                    end else begin
                        stall_c = 1'b1;
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cnt_q == 5'd0) begin
                    state_d = LAST;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            LAST: begin
                // The finishing instruction is still in EX; a new ex_muldiv
                // here belongs to it and must not retrigger.
                done_c  = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // A state left over from before reset must not leak a stall or a done
    // while reset is held; the abandoned operation simply disappears.
    assign muldiv_stall_o = reset && stall_c;
    assign muldiv_done_o  = reset && done_c;
    assign state_o        = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Central stall/flush controller of the 5-stage MIPS pipeline. Detects
//   load-use hazards, squashes wrong-path instructions on taken branches and
//   ID-resolved jumps, and freezes the front end while a multi-cycle mul/div
//   occupies EX. All controls are combinational from inputs and FSM state.
//
//   Priority, highest first: mul/div freeze, EX taken branch, load-use, jump.
//
//   Parameters
//     MULDIV_LAT       cycles a mul/div occupies EX (1..32, default 4)
//   Ports (inputs)
//     clk, reset       clock; synchronous active-low reset
//     id_rs_addr/id_rt_addr, id_uses_rs/id_uses_rt   ID operand usage
//     id_jump          ID holds j/jal/jr/jalr
//     ex_mem_read, ex_rt_addr                        EX load and destination
//     ex_branch_taken  branch in EX resolved taken
//     ex_muldiv        EX holds mult/multu/div/divu
//   Ports (outputs)
//     pc_wr_en, if_id_wr_en, id_ex_wr_en             register write enables
//     if_id_flush, id_ex_flush, ex_mem_flush         bubble insertion
//     muldiv_done      mul/div result valid
//     perf_stall, perf_flush, perf_muldiv            32-bit event counters
//     muldiv_state_o   mul/div FSM state (debug visibility)
//
//   Build option: HAZARD_PERF_EN enables the three wrapping event counters;
//   without it the counter ports are constant zero and no flops exist.
//
//   Inputs are plain levels with no handshake; they must be stable before
//   the rising edge.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    id_rs_addr,
    input  logic [4:0]    id_rt_addr,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic          id_jump,
    input  logic          ex_mem_read,
    input  logic [4:0]    ex_rt_addr,
    input  logic          ex_branch_taken,
    input  logic          ex_muldiv,
    output logic          pc_wr_en,
    output logic          if_id_wr_en,
    output logic          if_id_flush,
    output logic          id_ex_wr_en,
    output logic          id_ex_flush,
    output logic          ex_mem_flush,
    output logic          muldiv_done,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_flush,
    output logic [31:0]   perf_muldiv,
    output muldiv_state_e muldiv_state_o
);

    logic muldiv_stall;
    logic load_use;

    muldiv_stall_fsm #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_fsm (
        .clk            (clk),
        .reset          (reset),
        .ex_muldiv_i    (ex_muldiv),
        .muldiv_stall_o (muldiv_stall),
        .muldiv_done_o  (muldiv_done),
        .state_o        (muldiv_state_o)
    );

    // A load into $zero produces nothing to wait for.
    assign load_use = ex_mem_read && (ex_rt_addr != REG_ZERO) &&
                      (reg_hit(id_uses_rs, id_rs_addr, ex_rt_addr) ||
                       reg_hit(id_uses_rt, id_rt_addr, ex_rt_addr));

    always_comb begin
        pc_wr_en     = 1'b1;
        if_id_wr_en  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_wr_en  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!reset) begin
            // Enable and clear everything so the pipe fills with bubbles.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (muldiv_stall) begin
            // Hold IF/ID/EX and let bubbles drain into MEM.
            pc_wr_en     = 1'b0;
            if_id_wr_en  = 1'b0;
            id_ex_wr_en  = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            // Both younger instructions are wrong-path, including any jump
            // or load-use consumer in ID.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_wr_en     = 1'b0;
            if_id_wr_en  = 1'b0;
            id_ex_flush  = 1'b1;
        end else if (id_jump) begin
            // A jump stalled by load-use waits until its operand is ready.
            if_id_flush  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q,  perf_stall_d;
    logic [31:0] perf_flush_q,  perf_flush_d;
    logic [31:0] perf_muldiv_q, perf_muldiv_d;
    logic        lu_stall_evt;

    // Only load-use stalls that actually win the priority are counted.
    assign lu_stall_evt = !muldiv_stall && !ex_branch_taken && load_use;

    always_comb begin
        perf_stall_d  = perf_stall_q  + {31'd0, lu_stall_evt};
        perf_flush_d  = perf_flush_q  + {31'd0, if_id_flush};
        perf_muldiv_d = perf_muldiv_q + {31'd0, muldiv_stall};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_q  <= 32'd0;
            perf_flush_q  <= 32'd0;
            perf_muldiv_q <= 32'd0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_flush_q  <= perf_flush_d;
            perf_muldiv_q <= perf_muldiv_d;
        end
    end

    assign perf_stall  = perf_stall_q;
    assign perf_flush  = perf_flush_q;
    assign perf_muldiv = perf_muldiv_q;
`else
    assign perf_stall  = 32'd0;
    assign perf_flush  = 32'd0;
    assign perf_muldiv = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rt_addr;
  logic       id_uses_rs, id_uses_rt, id_jump;
  logic       ex_mem_read, ex_branch_taken, ex_muldiv;

  // DUT with default latency 4
  logic pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush, ex_mem_flush, muldiv_done;
  logic [31:0] perf_stall, perf_flush, perf_muldiv;
  muldiv_state_e md_state;

  // DUT with latency 1
  logic pc_wr_en_1, if_id_wr_en_1, if_id_flush_1, id_ex_wr_en_1, id_ex_flush_1, ex_mem_flush_1, muldiv_done_1;
  logic [31:0] perf_stall_1, perf_flush_1, perf_muldiv_1;
  muldiv_state_e md_state_1;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_rt_addr(ex_rt_addr),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv(ex_muldiv),
    .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en), .if_id_flush(if_id_flush),
    .id_ex_wr_en(id_ex_wr_en), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .muldiv_done(muldiv_done),
    .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_muldiv(perf_muldiv),
    .muldiv_state_o(md_state)
  );

  hazard_ctrl #(.MULDIV_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_rt_addr(ex_rt_addr),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv(ex_muldiv),
    .pc_wr_en(pc_wr_en_1), .if_id_wr_en(if_id_wr_en_1), .if_id_flush(if_id_flush_1),
    .id_ex_wr_en(id_ex_wr_en_1), .id_ex_flush(id_ex_flush_1), .ex_mem_flush(ex_mem_flush_1),
    .muldiv_done(muldiv_done_1),
    .perf_stall(perf_stall_1), .perf_flush(perf_flush_1), .perf_muldiv(perf_muldiv_1),
    .muldiv_state_o(md_state_1)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];

  // Control vector order: {pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_mem_flush, done}
  localparam logic [6:0] C_IDLE  = 7'b1101000;
  localparam logic [6:0] C_RST   = 7'b1111110;
  localparam logic [6:0] C_LU    = 7'b0001100;
  localparam logic [6:0] C_BR    = 7'b1111100;
  localparam logic [6:0] C_JMP   = 7'b1111000;
  localparam logic [6:0] C_MDST  = 7'b0000010;
  localparam logic [6:0] C_DONE  = 7'b1101001;

  // ---------------- reference model ----------------
  // k = how many cycles the current mul/div has already spent in EX (0 = none).
  int k4 = 0;
  int k1 = 0;
  logic [31:0] m_ps = 0, m_pf = 0, m_pm = 0;

  logic [6:0]  obs4, obs1, e4, e1;
  logic [31:0] ep_s, ep_f, ep_m;

  function automatic bit md_stall(input int k, input int lat, input logic em);
    if (k > 0) return (k < lat - 1);
    return em && (lat > 1);
  endfunction

  function automatic bit md_done(input int k, input int lat, input logic em);
    if (k > 0) return (k == lat - 1);
    return em && (lat == 1);
  endfunction

  function automatic int md_next(input int k, input int lat, input logic em);
    if (k == 0) return (em && lat > 1) ? 1 : 0;
    if (k == lat - 1) return 0;
    return k + 1;
  endfunction

  function automatic bit lu_now();
    if (!ex_mem_read || ex_rt_addr == 5'd0) return 0;
    return (id_uses_rs && id_rs_addr == ex_rt_addr) || (id_uses_rt && id_rt_addr == ex_rt_addr);
  endfunction

  function automatic logic [6:0] exp_ctrl(input int k, input int lat);
    logic d;
    if (!reset) return C_RST;
    if (md_stall(k, lat, ex_muldiv)) return C_MDST;
    d = md_done(k, lat, ex_muldiv);
    if (ex_branch_taken) return {6'b111110, d};
    if (lu_now()) return {6'b000110, d};
    if (id_jump) return {6'b111100, d};
    return {6'b110100, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clr_inputs();
    id_rs_addr = 0; id_rt_addr = 0; ex_rt_addr = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
    ex_mem_read = 0; ex_branch_taken = 0; ex_muldiv = 0;
  endtask

  // Wait to the falling edge, capture outputs and model predictions.
  task automatic settle();
    @(negedge clk);
    obs4 = {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush, ex_mem_flush, muldiv_done};
    obs1 = {pc_wr_en_1, if_id_wr_en_1, if_id_flush_1, id_ex_wr_en_1, id_ex_flush_1, ex_mem_flush_1, muldiv_done_1};
    e4 = exp_ctrl(k4, 4);
    e1 = exp_ctrl(k1, 1);
`ifdef HAZARD_PERF_EN
    ep_s = m_ps; ep_f = m_pf; ep_m = m_pm;
`else
    ep_s = 0; ep_f = 0; ep_m = 0;
`endif
  endtask

  // Advance the model across the next rising edge, then step past it.
  task automatic advance();
    if (!reset) begin
      k4 = 0; k1 = 0; m_ps = 0; m_pf = 0; m_pm = 0;
    end else begin
      if (md_stall(k4, 4, ex_muldiv)) m_pm = m_pm + 1;
      else if (ex_branch_taken) m_pf = m_pf + 1;
      else if (lu_now()) m_ps = m_ps + 1;
      else if (id_jump) m_pf = m_pf + 1;
      k4 = md_next(k4, 4, ex_muldiv);
      k1 = md_next(k1, 1, ex_muldiv);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_inputs();
    reset = 0;
    ex_mem_read = 1; ex_rt_addr = 8; id_rs_addr = 8; id_uses_rs = 1;
    ex_muldiv = 1; id_jump = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (obs4 !== C_RST) begin failures++; $display("FAIL reset_ctrl got %b want %b", obs4, C_RST); end
      checks++; if (obs1 !== C_RST) begin failures++; $display("FAIL reset_ctrl_lat1 got %b want %b", obs1, C_RST); end
      checks++; if ({perf_stall, perf_flush, perf_muldiv} !== 96'd0) begin failures++;
        $display("FAIL reset_perf got %0d/%0d/%0d want 0/0/0", perf_stall, perf_flush, perf_muldiv); end
      checks++; if (md_state !== RUN) begin failures++; $display("FAIL reset_state got %0d want %0d", md_state, RUN); end
      advance();
    end
    clr_inputs();
    reset = 1;
    settle();
    checks++; if (obs4 !== C_IDLE) begin failures++; $display("FAIL idle_ctrl got %b want %b", obs4, C_IDLE); end
    advance();
  endtask

  task automatic test_load_use();
    clr_inputs();
    ex_mem_read = 1; ex_rt_addr = 8; id_rs_addr = 8; id_uses_rs = 1;
    settle();
    checks++; if (obs4 !== C_LU) begin failures++; $display("FAIL lu_rs got %b want %b", obs4, C_LU); end
    advance();
    ex_rt_addr = 0; id_rs_addr = 0;
    settle();
    checks++; if (obs4 !== C_IDLE) begin failures++; $display("FAIL lu_zero got %b want %b", obs4, C_IDLE); end
    advance();
    id_uses_rs = 0; id_rs_addr = 5; id_uses_rt = 1; id_rt_addr = 17; ex_rt_addr = 17;
    settle();
    checks++; if (obs4 !== C_LU) begin failures++; $display("FAIL lu_rt got %b want %b", obs4, C_LU); end
    advance();
    id_uses_rt = 0;
    settle();
    checks++; if (obs4 !== C_IDLE) begin failures++; $display("FAIL lu_unused got %b want %b", obs4, C_IDLE); end
    advance();
    id_uses_rt = 1; ex_mem_read = 0;
    settle();
    checks++; if (obs4 !== C_IDLE) begin failures++; $display("FAIL lu_noload got %b want %b", obs4, C_IDLE); end
    advance();
  endtask

  task automatic test_branch_over_lu();
    clr_inputs();
    ex_mem_read = 1; ex_rt_addr = 8; id_rs_addr = 8; id_uses_rs = 1;
    ex_branch_taken = 1; id_jump = 1;
    settle();
    checks++; if (obs4 !== C_BR) begin failures++; $display("FAIL branch_lu got %b want %b", obs4, C_BR); end
    advance();
  endtask

  task automatic test_jump_blocked();
    clr_inputs();
    ex_mem_read = 1; ex_rt_addr = 31; id_rs_addr = 31; id_uses_rs = 1; id_jump = 1;
    settle();
    checks++; if (obs4 !== C_LU) begin failures++; $display("FAIL jump_blocked got %b want %b", obs4, C_LU); end
    advance();
    ex_mem_read = 0;
    settle();
    checks++; if (obs4 !== C_JMP) begin failures++; $display("FAIL jump_release got %b want %b", obs4, C_JMP); end
    advance();
  endtask

  task automatic test_back_to_back_muldiv();
    logic [6:0] want;
    clr_inputs();
    ex_muldiv = 1;
    for (int c = 0; c < 8; c++) begin
      want = ((c % 4) == 3) ? C_DONE : C_MDST;
      settle();
      checks++; if (obs4 !== want) begin failures++; $display("FAIL muldiv_c%0d got %b want %b", c, obs4, want); end
      checks++; if (obs1 !== C_DONE) begin failures++; $display("FAIL muldiv_lat1_c%0d got %b want %b", c, obs1, C_DONE); end
      advance();
    end
    ex_muldiv = 0;
    settle();
    checks++; if (obs4 !== C_IDLE) begin failures++; $display("FAIL muldiv_after got %b want %b", obs4, C_IDLE); end
    checks++; if (md_state !== RUN) begin failures++; $display("FAIL muldiv_state got %0d want %0d", md_state, RUN); end
    advance();
  endtask

  task automatic test_reset_mid_busy();
    clr_inputs();
    ex_muldiv = 1;
    settle();
    checks++; if (obs4 !== C_MDST) begin failures++; $display("FAIL rmb_start got %b want %b", obs4, C_MDST); end
    advance();
    reset = 0;
    settle();
    checks++; if (obs4 !== C_RST) begin failures++; $display("FAIL rmb_reset got %b want %b", obs4, C_RST); end
    advance();
    reset = 1; ex_muldiv = 0;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (obs4 !== C_IDLE) begin failures++; $display("FAIL rmb_after_c%0d got %b want %b", c, obs4, C_IDLE); end
      checks++; if (md_state !== RUN) begin failures++; $display("FAIL rmb_state_c%0d got %0d want %0d", c, md_state, RUN); end
      advance();
    end
  endtask

  task automatic test_perf();
    logic [31:0] want_s, want_m;
`ifdef HAZARD_PERF_EN
    want_s = 3; want_m = 3;
`else
    want_s = 0; want_m = 0;
`endif
    clr_inputs();
    reset = 0;
    settle();
    advance();
    reset = 1;
    ex_mem_read = 1; ex_rt_addr = 9; id_rt_addr = 9; id_uses_rt = 1;
    for (int c = 0; c < 3; c++) begin settle(); advance(); end
    clr_inputs();
    ex_muldiv = 1;
    for (int c = 0; c < 4; c++) begin settle(); advance(); end
    ex_muldiv = 0;
    settle();
    checks++; if (perf_stall !== want_s) begin failures++; $display("FAIL perf_stall got %0d want %0d", perf_stall, want_s); end
    checks++; if (perf_muldiv !== want_m) begin failures++; $display("FAIL perf_muldiv got %0d want %0d", perf_muldiv, want_m); end
    checks++; if (perf_flush !== 32'd0) begin failures++; $display("FAIL perf_flush got %0d want 0", perf_flush); end
    advance();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    for (int n = 0; n < 400; n++) begin
      reset           = ($urandom_range(0, 39) != 0);
      id_rs_addr      = 5'($urandom_range(0, 3));
      id_rt_addr      = 5'($urandom_range(0, 3));
      ex_rt_addr      = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_jump         = ($urandom_range(0, 3) == 0);
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      ex_muldiv       = ($urandom_range(0, 5) == 0);
      settle();
      exp_q.push_back(e4);
      exp = exp_q.pop_front();
      checks++; if (obs4 !== exp) begin failures++; $display("FAIL rand_ctrl n=%0d got %b want %b", n, obs4, exp); end
      checks++; if (obs1 !== e1) begin failures++; $display("FAIL rand_ctrl_lat1 n=%0d got %b want %b", n, obs1, e1); end
      checks++; if ({perf_stall, perf_flush, perf_muldiv} !== {ep_s, ep_f, ep_m}) begin failures++;
        $display("FAIL rand_perf n=%0d got %0d/%0d/%0d want %0d/%0d/%0d", n, perf_stall, perf_flush, perf_muldiv, ep_s, ep_f, ep_m); end
      advance();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clr_inputs();
    reset = 0;
    test_reset();
    test_load_use();
    test_branch_over_lu();
    test_jump_blocked();
    test_back_to_back_muldiv();
    test_reset_mid_busy();
    test_perf();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
